// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing generator (sync, active, x/y, events).
// Optional line-compare interrupt enabled by defining VGA_TIMING_LINE_IRQ_EN.
module vga_timing_gen #(
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10,
   parameter int HS_POL = 0,
   parameter int VS_POL = 0,
   parameter int CW     = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
`ifdef VGA_TIMING_LINE_IRQ_EN
   input  logic [CW-1:0] irq_line,
   output logic          line_irq,
`endif
   output logic          h_sync,
   output logic          v_sync,
   output logic          active,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          sof,
   output logic          eol,
   output logic [15:0]   frame_cnt
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int H_START = H_SYNC + H_BP;
   localparam int V_START = V_SYNC + V_BP;

   // One extra bit so an end bound equal to 2^CW still compares correctly.
   localparam logic [CW:0] HS_END = (CW+1)'(H_SYNC);
   localparam logic [CW:0] VS_END = (CW+1)'(V_SYNC);
   localparam logic [CW:0] HA_BEG = (CW+1)'(H_START);
   localparam logic [CW:0] HA_END = (CW+1)'(H_START + H_ACT);
   localparam logic [CW:0] VA_BEG = (CW+1)'(V_START);
   localparam logic [CW:0] VA_END = (CW+1)'(V_START + V_ACT);
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_OFS  = CW'(H_START);
   localparam logic [CW-1:0] V_OFS  = CW'(V_START);
   localparam logic HS_ON = HS_POL[0];
   localparam logic VS_ON = VS_POL[0];

   logic [CW-1:0] h_cnt, v_cnt;
   logic [CW-1:0] h_nx, v_nx;
   logic [CW:0]   hx, vx;
   logic          h_wrap;
   logic          h_act_nx, v_act_nx, act_nx;
   logic          sof_nx, eol_nx;

   // Next position and the output values describing it.
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      h_nx   = h_wrap ? '0 : h_cnt + CW'(1);
      v_nx   = v_cnt;
      if (h_wrap)
         v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      hx       = {1'b0, h_nx};
      vx       = {1'b0, v_nx};
      h_act_nx = (hx >= HA_BEG) && (hx < HA_END);
      v_act_nx = (vx >= VA_BEG) && (vx < VA_END);
      act_nx   = h_act_nx && v_act_nx;
      sof_nx   = h_wrap && (v_nx == '0);
      eol_nx   = (hx == HA_END) && v_act_nx;
   end

   // Position counters and registered outputs; pulses last one clk cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         h_sync    <= HS_ON;
         v_sync    <= VS_ON;
         active    <= 1'b0;
         x         <= '0;
         y         <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         frame_cnt <= '0;
`ifdef VGA_TIMING_LINE_IRQ_EN
         line_irq  <= 1'b0;
`endif
      end else begin
         sof <= 1'b0;
         eol <= 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
         line_irq <= 1'b0;
`endif
         if (pix_en) begin
            h_cnt  <= h_nx;
            v_cnt  <= v_nx;
            h_sync <= (hx < HS_END) ? HS_ON : ~HS_ON;
            v_sync <= (vx < VS_END) ? VS_ON : ~VS_ON;
            active <= act_nx;
            x      <= act_nx ? h_nx - H_OFS : '0;
            y      <= act_nx ? v_nx - V_OFS : '0;
            sof    <= sof_nx;
            eol    <= eol_nx;
            if (sof_nx)
               frame_cnt <= frame_cnt + 16'd1;
`ifdef VGA_TIMING_LINE_IRQ_EN
            line_irq <= h_wrap && (v_nx == irq_line);
`endif
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at default timing
// and at a tiny active-high timing with pix_en toggling.
module tb_vga_timing_gen;

   logic        clk;
   logic        rst_n, pen;
   logic        s_rst, s_pen;

   logic        d_hs, d_vs, d_act, d_sof, d_eol;
   logic [11:0] d_x, d_y;
   logic [15:0] d_fc;

   logic        s_hs, s_vs, s_act, s_sof, s_eol;
   logic [3:0]  s_x, s_y;
   logic [15:0] s_fc;

`ifdef VGA_TIMING_LINE_IRQ_EN
   logic        d_irq, s_irq;
   logic [3:0]  s_irq_line;
   int          irqs;
`endif

   int errors = 0;
   int checks = 0;
   int p = 0;

   vga_timing_gen u_def (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_en    (pen),
`ifdef VGA_TIMING_LINE_IRQ_EN
      .irq_line  (12'd100),
      .line_irq  (d_irq),
`endif
      .h_sync    (d_hs),
      .v_sync    (d_vs),
      .active    (d_act),
      .x         (d_x),
      .y         (d_y),
      .sof       (d_sof),
      .eol       (d_eol),
      .frame_cnt (d_fc)
   );

   vga_timing_gen #(
      .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
      .HS_POL(1), .VS_POL(1), .CW(4)
   ) u_small (
      .clk       (clk),
      .rst_n     (s_rst),
      .pix_en    (s_pen),
`ifdef VGA_TIMING_LINE_IRQ_EN
      .irq_line  (s_irq_line),
      .line_irq  (s_irq),
`endif
      .h_sync    (s_hs),
      .v_sync    (s_vs),
      .active    (s_act),
      .x         (s_x),
      .y         (s_y),
      .sof       (s_sof),
      .eol       (s_eol),
      .frame_cnt (s_fc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance the default instance to strobe count t (pen held at 1).
   task automatic go(input int t);
      repeat (t - p) @(negedge clk);
      p = t;
   endtask

   initial begin
      int sh, sv, sofs;
      logic adv, e_act;
      logic [3:0] ex, ey;

      rst_n = 1'b0;
      s_rst = 1'b0;
      pen   = 1'b0;
      s_pen = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
      s_irq_line = 4'd3;
      irqs = 0;
`endif
      repeat (3) @(negedge clk);

      chk("def_rst_sync", {d_hs, d_vs}, 2'b00);
      chk("def_rst_misc", {d_act, d_sof, d_eol, d_x, d_y, d_fc},
          '0);
      chk("small_rst_sync", {s_hs, s_vs}, 2'b11);
      chk("small_rst_misc", {s_act, s_sof, s_eol, s_x, s_y, s_fc},
          '0);

      // Small timing: H total 10 (active 4..7), V total 6 (active 2..4).
      s_rst = 1'b1;
      sh = 0;
      sv = 0;
      sofs = 0;
      for (int c = 0; c < 240; c++) begin
`ifdef VGA_TIMING_LINE_IRQ_EN
         if (c == 120) s_irq_line = 4'd6;
`endif
         s_pen = (c % 2 == 0);
         @(negedge clk);
         adv = s_pen;
         if (adv) begin
            if (sh == 9) begin
               sh = 0;
               sv = (sv == 5) ? 0 : sv + 1;
            end else begin
               sh = sh + 1;
            end
         end
         e_act = (sh >= 4) && (sh < 8) && (sv >= 2) && (sv < 5);
         ex = e_act ? 4'(sh - 4) : 4'd0;
         ey = e_act ? 4'(sv - 2) : 4'd0;
         chk("small_sync", {s_hs, s_vs}, {sh < 2, sv < 1});
         chk("small_act", s_act, e_act);
         chk("small_xy", {s_x, s_y}, {ex, ey});
         chk("small_sof", s_sof, adv && sh == 0 && sv == 0);
         chk("small_eol", s_eol, adv && sh == 8 && sv >= 2 && sv < 5);
         if (s_sof === 1'b1) sofs++;
`ifdef VGA_TIMING_LINE_IRQ_EN
         chk("small_irq", s_irq,
             adv && sh == 0 && 4'(sv) == s_irq_line);
         if (s_irq === 1'b1) irqs++;
`endif
      end
      chk("small_frame_cnt", s_fc, 16'd2);
      chk("small_sof_count", sofs, 2);
`ifdef VGA_TIMING_LINE_IRQ_EN
      chk("small_irq_count", irqs, 1);
`endif

      s_pen = 1'b0;
      #2 s_rst = 1'b0;
      #1;
      chk("small_async_fc", s_fc, 16'd0);
      chk("small_async_sync", {s_hs, s_vs, s_act}, 3'b110);

      // Default 640x480 timing, pen held at 1.
      @(negedge clk);
      rst_n = 1'b1;
      pen = 1'b1;
      p = 0;
      go(1);
      chk("hs_low_at_1", {d_hs, d_vs, d_sof}, 3'b000);
      go(95);
      chk("hs_low_at_95", d_hs, 1'b0);
      go(96);
      chk("hs_high_at_96", d_hs, 1'b1);
      go(799);
      chk("hs_high_at_799", d_hs, 1'b1);
      go(800);
      chk("hs_low_at_800", d_hs, 1'b0);
      go(1599);
      chk("vs_low_line1", d_vs, 1'b0);
      go(1600);
      chk("vs_high_line2", d_vs, 1'b1);
      go(35 * 800 + 143);
      chk("act_before_144", d_act, 1'b0);
      go(35 * 800 + 144);
      chk("act_first", {d_act, d_x, d_y}, {1'b1, 12'd0, 12'd0});
      go(35 * 800 + 154);
      chk("x_at_154", d_x, 12'd10);

      pen = 1'b0;
      repeat (3) @(negedge clk);
      chk("hold_x", {d_act, d_x, d_y}, {1'b1, 12'd10, 12'd0});
      pen = 1'b1;

      go(35 * 800 + 783);
      chk("last_x", {d_act, d_x, d_eol}, {1'b1, 12'd639, 1'b0});
      go(35 * 800 + 784);
      chk("eol_pulse", {d_act, d_x, d_eol}, {1'b0, 12'd0, 1'b1});
      go(35 * 800 + 785);
      chk("eol_clear", d_eol, 1'b0);
      go(36 * 800 + 300);
      chk("xy_300_36", {d_act, d_x, d_y}, {1'b1, 12'd156, 12'd1});
      chk("sync_300_36", {d_hs, d_vs}, 2'b11);

      #2 rst_n = 1'b0;
      #1;
      chk("async_sync", {d_hs, d_vs}, 2'b00);
      chk("async_misc", {d_act, d_x, d_y, d_eol, d_fc}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      p = 0;
      go(1);
      chk("post_rst_pos", {d_hs, d_vs, d_act, d_sof}, 4'b0000);
      go(96);
      chk("post_rst_hs", d_hs, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
